// File: rtl/v_in_position_sampler_pkg.sv
// Shared types and constants for the video-in position sampler.
package v_in_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    WAIT_POS = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_SNAP   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_FRAMES = 2'd3;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_ONESHOT_BIT = 1;
  localparam int CTRL_DECIM_LSB   = 8;

  localparam int SNAP_VALID_BIT   = 31;
  localparam int SNAP_Y_LSB       = 16;
  localparam int STATUS_BUSY_BIT  = 31;

endpackage

// File: rtl/v_in_position_sampler_sat_counter.sv
// Counter with synchronous clear (priority over increment) and a
// build-time choice between saturating at all-ones or wrapping.
module sat_counter #(
  parameter int W        = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  // Count register: clear beats increment; saturate mode holds at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      if (SATURATE && (count == '1)) begin
        count <= count;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/v_in_position_sampler.sv
// Frame-synchronised capture of tracker (x, y) for the Nios, behind an
// Avalon-MM slave with snapshot, control, status and frame-count registers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | capture disabled
// WAIT_SOF | counting down decimated frames until the next start-of-frame
// WAIT_POS | selected frame running, waiting for its first pos_valid
module v_in_position_sampler
  import v_in_pkg::*;
#(
  parameter int POS_W   = 9,
  parameter int DECIM_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  input  logic             pos_valid,
  input  logic             frame_sync,
  output logic             snap_irq
);

  localparam logic [DECIM_W-1:0] DCNT_ONE = DECIM_W'(1);

  state_t             state, state_next;
  logic [DECIM_W-1:0] dcnt, dcnt_next;

  logic               ctrl_en;
  logic               ctrl_oneshot;
  logic [DECIM_W-1:0] ctrl_decim;

  logic [POS_W-1:0]   snap_x;
  logic [POS_W-1:0]   snap_y;
  logic               snap_valid;

  logic               capture;
  logic               oneshot_done;
  logic               wr_ctrl;
  logic               wr_status;
  logic               rd_snap;
  logic               ovr_inc;
  logic [CNT_W-1:0]   ovr_count;
  logic [CNT_W-1:0]   frame_count;
  logic [31:0]        rd_mux;
  logic               unused_wdata;

  assign wr_ctrl   = write && (address == ADDR_CTRL);
  assign wr_status = write && (address == ADDR_STATUS);
  assign rd_snap   = read  && (address == ADDR_SNAP);

  // A read landing on the same edge as a capture sees the old snapshot,
  // but the new one is still unread, so it is not an overrun.
  assign ovr_inc   = capture && snap_valid && !rd_snap;
  assign snap_irq  = snap_valid;

  assign unused_wdata = ^{writedata[31:CTRL_DECIM_LSB+DECIM_W],
                          writedata[CTRL_DECIM_LSB-1:CTRL_ONESHOT_BIT+1]};

  // State and decimation-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_next;
      dcnt  <= dcnt_next;
    end
  end

  // Next-state logic; a frame_sync in WAIT_POS is evaluated after any
  // same-cycle capture, so decim=0 keeps waiting for the next position.
  always_comb begin
    state_next   = state;
    dcnt_next    = dcnt;
    capture      = 1'b0;
    oneshot_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctrl_en) begin
          state_next = WAIT_SOF;
          dcnt_next  = '0;
        end
      end
      WAIT_SOF: begin
        if (frame_sync) begin
          if (dcnt == '0) begin
            state_next = WAIT_POS;
            dcnt_next  = ctrl_decim;
          end else begin
            dcnt_next  = dcnt - DCNT_ONE;
          end
        end
      end
      WAIT_POS: begin
        if (pos_valid) begin
          capture    = 1'b1;
          state_next = WAIT_SOF;
        end
        if (frame_sync) begin
          if (dcnt == '0) begin
            state_next = WAIT_POS;
            dcnt_next  = ctrl_decim;
          end else begin
            state_next = WAIT_SOF;
            dcnt_next  = dcnt - DCNT_ONE;
          end
        end
        if (pos_valid && ctrl_oneshot) begin
          state_next   = IDLE;
          oneshot_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (wr_ctrl && !writedata[CTRL_EN_BIT]) begin
      state_next = IDLE;
    end
  end

  // CTRL register; a completed one-shot clears the mode so CTRL reads back
  // idle, unless the CPU writes CTRL on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      ctrl_decim   <= '0;
    end else if (wr_ctrl) begin
      ctrl_en      <= writedata[CTRL_EN_BIT];
      ctrl_oneshot <= writedata[CTRL_ONESHOT_BIT];
      ctrl_decim   <= writedata[CTRL_DECIM_LSB +: DECIM_W];
    end else if (oneshot_done) begin
      ctrl_en      <= 1'b0;
      ctrl_oneshot <= 1'b0;
    end
  end

  // Snapshot register; a capture wins over the clear-on-read of valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_x     <= '0;
      snap_y     <= '0;
      snap_valid <= 1'b0;
    end else if (capture) begin
      snap_x     <= pos_x;
      snap_y     <= pos_y;
      snap_valid <= 1'b1;
    end else if (rd_snap) begin
      snap_valid <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W), .SATURATE(1'b1)) u_ovr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ovr_inc),
    .clr   (wr_status),
    .count (ovr_count)
  );

  sat_counter #(.W(CNT_W), .SATURATE(1'b0)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (frame_sync),
    .clr   (1'b0),
    .count (frame_count)
  );

  // Read-data mux; unused bits stay zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_SNAP: begin
        rd_mux[SNAP_VALID_BIT]         = snap_valid;
        rd_mux[SNAP_Y_LSB +: POS_W]    = snap_y;
        rd_mux[POS_W-1:0]              = snap_x;
      end
      ADDR_CTRL: begin
        rd_mux[CTRL_EN_BIT]                 = ctrl_en;
        rd_mux[CTRL_ONESHOT_BIT]            = ctrl_oneshot;
        rd_mux[CTRL_DECIM_LSB +: DECIM_W]   = ctrl_decim;
      end
      ADDR_STATUS: begin
        rd_mux[STATUS_BUSY_BIT] = (state != IDLE);
        rd_mux[CNT_W-1:0]       = ovr_count;
      end
      ADDR_FRAMES: begin
        rd_mux[CNT_W-1:0] = frame_count;
      end
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, held while read is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (read) begin
      readdata <= rd_mux;
    end
  end

endmodule
